// File: rtl/lsu_ctrl_pkg.sv
// Shared types and encodings for the MEM-stage load/store controller.
package lsu_ctrl_pkg;

  localparam int XLEN     = 32;
  localparam int BE_WIDTH = XLEN / 8;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} mem_size_t;

  // Access width from funct3; unused encodings behave as word accesses.
  function automatic mem_size_t decode_size(input logic [2:0] funct3);
    case (funct3)
      FUNCT3_LB, FUNCT3_LBU: decode_size = SIZE_BYTE;
      FUNCT3_LH, FUNCT3_LHU: decode_size = SIZE_HALF;
      FUNCT3_LW:             decode_size = SIZE_WORD;
      default:               decode_size = SIZE_WORD;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: is_misaligned = addr_lo[0];
      SIZE_WORD: is_misaligned = (addr_lo != 2'b00);
      default:   is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_load_align.sv
// Load lane extraction and sign/zero extension; purely combinational so the
// same block can sit behind a future cache read path.
module lsu_ctrl_load_align
  import lsu_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed lane, then extend it according to the load type.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can infer a latch.
    byte_lane = rdata[7:0];
    result    = rdata;
    case (addr_lo)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      FUNCT3_LB:  result = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      FUNCT3_LBU: result = {{(XLEN-8){1'b0}}, byte_lane};
      FUNCT3_LH:  result = {{(XLEN-16){half_lane[15]}}, half_lane};
      FUNCT3_LHU: result = {{(XLEN-16){1'b0}}, half_lane};
      default:    result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller: drives the data-memory req/gnt/rvalid
// port, stalls the pipeline while an access is in flight, lane-aligns
// sub-word stores and returns extended load data.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                exmemMemRead,
  input  logic                exmemMemWrite,
  input  logic [2:0]          exmemFunct3,
  input  logic [XLEN-1:0]     exmemAddr,
  input  logic [XLEN-1:0]     exmemWdata,
  output logic                memStall,
  output logic                loadDone,
  output logic [XLEN-1:0]     memRdata,
  output logic                misaligned,
  output logic                dmemReq,
  output logic                dmemWe,
  output logic [XLEN-1:0]     dmemAddr,
  output logic [BE_WIDTH-1:0] dmemBe,
  output logic [XLEN-1:0]     dmemWdata,
  input  logic                dmemGnt,
  input  logic                dmemRvalid,
  input  logic [XLEN-1:0]     dmemRdata
);

  lsu_state_t      state;
  mem_size_t       size;
  logic            is_load;
  logic            is_store;
  logic            valid_op;
  logic            bad_align;
  logic            issue;
  logic            capture;
  logic [XLEN-1:0] aligned_rdata;

  // A load wins when both read and write are flagged.
  assign is_load   = exmemMemRead;
  assign is_store  = exmemMemWrite & ~exmemMemRead;
  assign valid_op  = is_load | is_store;
  assign size      = decode_size(exmemFunct3);
  assign bad_align = valid_op & is_misaligned(size, exmemAddr[1:0]);
  assign issue     = valid_op & ~bad_align;
  assign capture   = (state == WAIT) & dmemRvalid;

  lsu_ctrl_load_align u_load_align (
    .rdata   (dmemRdata),
    .addr_lo (exmemAddr[1:0]),
    .funct3  (exmemFunct3),
    .result  (aligned_rdata)
  );

  // Stall/request decode from state and the op held in EX/MEM; reset forces both low.
  always_comb begin
    memStall = 1'b0;
    dmemReq  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          memStall = issue;
          dmemReq  = issue;
        end
        REQ: begin
          memStall = 1'b1;
          dmemReq  = 1'b1;
        end
        WAIT:    memStall = 1'b1;
        default: memStall = 1'b0;
      endcase
    end
  end

  assign misaligned = ~rst & (state == IDLE) & bad_align;
  assign dmemWe     = dmemReq & is_store;
  assign dmemAddr   = {exmemAddr[XLEN-1:2], 2'b00};

  // Store lane placement; loads enable every byte of the word.
  always_comb begin
    dmemBe    = {BE_WIDTH{1'b1}};
    dmemWdata = exmemWdata;
    if (is_store) begin
      case (exmemFunct3)
        FUNCT3_SB: begin
          dmemBe    = 4'b0001 << exmemAddr[1:0];
          dmemWdata = {4{exmemWdata[7:0]}};
        end
        FUNCT3_SH: begin
          dmemBe    = 4'b0011 << {exmemAddr[1], 1'b0};
          dmemWdata = {2{exmemWdata[15:0]}};
        end
        FUNCT3_SW: dmemBe = 4'b1111;
        default:   dmemBe = 4'b1111;
      endcase
    end
  end

  // Access sequencing: IDLE issues, REQ holds until grant, WAIT holds until data, DONE releases.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (issue)      state <= dmemGnt ? (is_load ? WAIT : DONE) : REQ;
        REQ:  if (dmemGnt)    state <= is_load ? WAIT : DONE;
        WAIT: if (dmemRvalid) state <= DONE;
        default:              state <= IDLE;
      endcase
    end
  end

  // Load result is valid only during DONE; it reads as zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memRdata <= '0;
      loadDone <= 1'b0;
    end else begin
      memRdata <= capture ? aligned_rdata : '0;
      loadDone <= capture;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: the driver pushes expected memory requests,
// load results and misaligned pulses into a queue; a monitor pops and
// compares whenever the DUT presents one of those events.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                exmemMemRead = 1'b0;
  logic                exmemMemWrite = 1'b0;
  logic [2:0]          exmemFunct3 = 3'b000;
  logic [XLEN-1:0]     exmemAddr = '0;
  logic [XLEN-1:0]     exmemWdata = '0;
  logic                memStall;
  logic                loadDone;
  logic [XLEN-1:0]     memRdata;
  logic                misaligned;
  logic                dmemReq;
  logic                dmemWe;
  logic [XLEN-1:0]     dmemAddr;
  logic [BE_WIDTH-1:0] dmemBe;
  logic [XLEN-1:0]     dmemWdata;
  logic                dmemGnt = 1'b0;
  logic                dmemRvalid = 1'b0;
  logic [XLEN-1:0]     dmemRdata = '0;

  lsu_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .exmemMemRead  (exmemMemRead),
    .exmemMemWrite (exmemMemWrite),
    .exmemFunct3   (exmemFunct3),
    .exmemAddr     (exmemAddr),
    .exmemWdata    (exmemWdata),
    .memStall      (memStall),
    .loadDone      (loadDone),
    .memRdata      (memRdata),
    .misaligned    (misaligned),
    .dmemReq       (dmemReq),
    .dmemWe        (dmemWe),
    .dmemAddr      (dmemAddr),
    .dmemBe        (dmemBe),
    .dmemWdata     (dmemWdata),
    .dmemGnt       (dmemGnt),
    .dmemRvalid    (dmemRvalid),
    .dmemRdata     (dmemRdata)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_REQ, EV_LOAD, EV_MIS} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  accepted = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_t kind, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] rdata);
    ev_t e;
    e.kind = kind; e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge and compares each presented event.
  always @(negedge clk) begin
    if (!rst) begin
      if (dmemReq && dmemGnt) begin
        accepted++;
        if (exp_q.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("req_kind", 32'(e.kind), 32'(EV_REQ));
          check("req_addr", dmemAddr, e.addr);
          check("req_we", 32'(dmemWe), 32'(e.we));
          check("req_be", 32'(dmemBe), 32'(e.be));
          if (e.we) check("req_wdata", dmemWdata, e.wdata);
        end
      end
      if (loadDone) begin
        if (exp_q.size() == 0) begin
          check("unexpected_load", 32'd1, 32'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("load_kind", 32'(e.kind), 32'(EV_LOAD));
          check("load_rdata", memRdata, e.rdata);
        end
      end
      if (misaligned) begin
        if (exp_q.size() == 0) begin
          check("unexpected_mis", 32'd1, 32'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("mis_kind", 32'(e.kind), 32'(EV_MIS));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    exmemMemRead = rd; exmemMemWrite = wr; exmemFunct3 = f3;
    exmemAddr = addr; exmemWdata = wdata;
  endtask

  // One aligned access from IDLE through DONE; leaves EX/MEM empty in IDLE.
  task automatic do_op(input logic rd, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                       input logic [31:0] rdata, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_rdata);
    push(EV_REQ, ~rd, exp_addr, exp_be, exp_wdata, 32'h0);
    if (rd) push(EV_LOAD, 1'b0, 32'h0, 4'h0, 32'h0, exp_rdata);
    set_op(rd, ~rd, f3, addr, wdata);
    for (int i = 0; i <= gnt_dly; i++) begin
      dmemGnt = (i == gnt_dly);
      @(negedge clk);
      check("req_stall", 32'(memStall), 32'd1);
      check("req_held", 32'(dmemReq), 32'd1);
      check("req_addr_stable", dmemAddr, exp_addr);
      check("req_be_stable", 32'(dmemBe), 32'(exp_be));
      if (!rd) check("req_wdata_stable", dmemWdata, exp_wdata);
      next_cycle();
    end
    dmemGnt = 1'b0;
    if (rd) begin
      for (int i = 0; i <= rv_dly; i++) begin
        dmemRvalid = (i == rv_dly);
        dmemRdata  = (i == rv_dly) ? rdata : 32'hA5A5_A5A5;
        @(negedge clk);
        check("wait_stall", 32'(memStall), 32'd1);
        check("wait_no_req", 32'(dmemReq), 32'd0);
        next_cycle();
      end
      dmemRvalid = 1'b0;
    end
    @(negedge clk);
    check("done_no_stall", 32'(memStall), 32'd0);
    check("done_load_pulse", 32'(loadDone), 32'(rd));
    next_cycle();
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  // Misaligned op presented in IDLE: one pulse, nothing issued.
  task automatic do_mis(input logic rd, input logic [2:0] f3, input logic [31:0] addr);
    push(EV_MIS, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    set_op(rd, ~rd, f3, addr, 32'hFFFF_FFFF);
    @(negedge clk);
    check("mis_pulse", 32'(misaligned), 32'd1);
    check("mis_no_req", 32'(dmemReq), 32'd0);
    check("mis_no_stall", 32'(memStall), 32'd0);
    check("mis_no_load", 32'(loadDone), 32'd0);
    check("mis_rdata", memRdata, 32'h0);
    next_cycle();
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    int acc0;
    // Reset with a load sitting in EX/MEM: stall and request must stay low.
    set_op(1'b1, 1'b0, FUNCT3_LW, 32'h100, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(memStall), 32'd0);
    check("rst_req", 32'(dmemReq), 32'd0);
    check("rst_load", 32'(loadDone), 32'd0);
    check("rst_rdata", memRdata, 32'h0);
    check("rst_mis", 32'(misaligned), 32'd0);
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    next_cycle();
    rst = 1'b0;

    // Word load, immediate grant, data one cycle later.
    do_op(1'b1, FUNCT3_LW, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, 32'h100, 4'hF, 32'h0, 32'hDEAD_BEEF);

    // Sub-word load extraction and extension.
    do_op(1'b1, FUNCT3_LB,  32'h103, 32'h0, 0, 0, 32'h80FF_FF7F, 32'h100, 4'hF, 32'h0, 32'hFFFF_FF80);
    do_op(1'b1, FUNCT3_LBU, 32'h103, 32'h0, 1, 2, 32'h80FF_FF7F, 32'h100, 4'hF, 32'h0, 32'h0000_0080);
    do_op(1'b1, FUNCT3_LHU, 32'h102, 32'h0, 0, 0, 32'h80FF_FF7F, 32'h100, 4'hF, 32'h0, 32'h0000_80FF);
    do_op(1'b1, FUNCT3_LH,  32'h102, 32'h0, 0, 1, 32'h80FF_FF7F, 32'h100, 4'hF, 32'h0, 32'hFFFF_80FF);
    do_op(1'b1, FUNCT3_LB,  32'h100, 32'h0, 0, 0, 32'h80FF_FF7F, 32'h100, 4'hF, 32'h0, 32'h0000_007F);

    // Stores: delayed grant with stable request, then byte and word lanes.
    do_op(1'b0, FUNCT3_SH, 32'h0A, 32'h1234_ABCD, 3, 0, 32'h0, 32'h08, 4'b1100, 32'hABCD_ABCD, 32'h0);
    do_op(1'b0, FUNCT3_SB, 32'h0D, 32'h0000_00CD, 0, 0, 32'h0, 32'h0C, 4'b0010, 32'hCDCD_CDCD, 32'h0);
    do_op(1'b0, FUNCT3_SW, 32'h20, 32'hCAFE_F00D, 1, 0, 32'h0, 32'h20, 4'b1111, 32'hCAFE_F00D, 32'h0);

    // Misaligned accesses are dropped with a pulse.
    do_mis(1'b1, FUNCT3_LW,  32'h102);
    do_mis(1'b0, FUNCT3_SH,  32'h0B);
    do_mis(1'b1, FUNCT3_LHU, 32'h101);
    do_mis(1'b0, FUNCT3_SW,  32'h41);

    // Store then load back to back, then a stray rvalid in IDLE.
    acc0 = accepted;
    do_op(1'b0, FUNCT3_SW, 32'h40, 32'h1122_3344, 0, 0, 32'h0, 32'h40, 4'hF, 32'h1122_3344, 32'h0);
    do_op(1'b1, FUNCT3_LW, 32'h40, 32'h0, 0, 0, 32'h1122_3344, 32'h40, 4'hF, 32'h0, 32'h1122_3344);
    dmemRvalid = 1'b1;
    dmemRdata  = 32'h7777_7777;
    @(negedge clk);
    check("idle_rvalid_stall", 32'(memStall), 32'd0);
    next_cycle();
    dmemRvalid = 1'b0;
    @(negedge clk);
    check("idle_rvalid_ignored", 32'(loadDone), 32'd0);
    check("idle_rvalid_rdata", memRdata, 32'h0);
    check("b2b_request_count", 32'(accepted - acc0), 32'd2);
    next_cycle();

    // Reset while waiting for read data, then a late response.
    push(EV_REQ, 1'b0, 32'h200, 4'hF, 32'h0, 32'h0);
    set_op(1'b1, 1'b0, FUNCT3_LW, 32'h200, 32'h0);
    dmemGnt = 1'b1;
    next_cycle();
    dmemGnt = 1'b0;
    @(negedge clk);
    check("wait_before_rst", 32'(memStall), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midop_rst_stall", 32'(memStall), 32'd0);
    check("midop_rst_req", 32'(dmemReq), 32'd0);
    next_cycle();
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    next_cycle();
    rst = 1'b0;
    dmemRvalid = 1'b1;
    dmemRdata  = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("late_rvalid_load", 32'(loadDone), 32'd0);
      check("late_rvalid_rdata", memRdata, 32'h0);
      check("late_rvalid_stall", 32'(memStall), 32'd0);
      check("late_rvalid_req", 32'(dmemReq), 32'd0);
      check("late_rvalid_mis", 32'(misaligned), 32'd0);
      next_cycle();
    end
    dmemRvalid = 1'b0;
    next_cycle();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "bench did not complete");
  end

endmodule
